// File: rtl/id_ex_hazard_reg_if.sv
// ID/EX boundary bundle: decoded ID fields and pipeline controls in, EX-stage
// register copies plus stall status out.
interface id_ex_hazard_reg_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 11
);
  logic              hold_i;
  logic              flush_i;
  logic              clr_cnt_i;
  logic              id_valid_i;
  logic [XLEN-1:0]   id_pc_i;
  logic [4:0]        id_rs1_i;
  logic [4:0]        id_rs2_i;
  logic [4:0]        id_rd_i;
  logic              id_rs1_used_i;
  logic              id_rs2_used_i;
  logic [XLEN-1:0]   id_rs1_data_i;
  logic [XLEN-1:0]   id_rs2_data_i;
  logic [XLEN-1:0]   id_imm_i;
  logic [CTRL_W-1:0] id_ctrl_i;

  logic              ex_valid_o;
  logic [XLEN-1:0]   ex_pc_o;
  logic [XLEN-1:0]   ex_rs1_data_o;
  logic [XLEN-1:0]   ex_rs2_data_o;
  logic [XLEN-1:0]   ex_imm_o;
  logic [4:0]        ex_rs1_o;
  logic [4:0]        ex_rs2_o;
  logic [4:0]        ex_rd_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic              stall_o;
  logic [31:0]       stall_cnt_o;

  modport master (
    output hold_i, flush_i, clr_cnt_i, id_valid_i, id_pc_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_rs1_used_i, id_rs2_used_i,
           id_rs1_data_i, id_rs2_data_i, id_imm_i, id_ctrl_i,
    input  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, ex_ctrl_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  hold_i, flush_i, clr_cnt_i, id_valid_i, id_pc_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_rs1_used_i, id_rs2_used_i,
           id_rs1_data_i, id_rs2_data_i, id_imm_i, id_ctrl_i,
    output ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, ex_ctrl_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register for the RV32I core with load-use hazard detection,
// bubble insertion on hazard/flush, global hold, and a saturating stall counter.
module id_ex_hazard_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 11
) (
  input logic               clk_i,
  input logic               rst_n_i,
  id_ex_hazard_reg_if.slave bus
);
  localparam int MEM_READ = 1;

  logic              ex_valid_p1;
  logic [XLEN-1:0]   ex_pc_p1;
  logic [XLEN-1:0]   ex_rs1_data_p1;
  logic [XLEN-1:0]   ex_rs2_data_p1;
  logic [XLEN-1:0]   ex_imm_p1;
  logic [4:0]        ex_rs1_p1;
  logic [4:0]        ex_rs2_p1;
  logic [4:0]        ex_rd_p1;
  logic [CTRL_W-1:0] ex_ctrl_p1;
  logic [31:0]       stall_cnt_p1;

  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic stall;
  logic bubble;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    rs1_hit  = bus.id_rs1_used_i && (bus.id_rs1_i == ex_rd_p1);
    rs2_hit  = bus.id_rs2_used_i && (bus.id_rs2_i == ex_rd_p1);
    load_use = ex_valid_p1 && ex_ctrl_p1[MEM_READ] && (ex_rd_p1 != 5'd0) &&
               bus.id_valid_i && (rs1_hit || rs2_hit);
    // A flush kills the dependent instruction anyway, so let IF/ID advance.
    stall    = load_use && !bus.flush_i;
    bubble   = bus.flush_i || load_use;
  end

  // ---- ID -> EX stage boundary ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_valid_p1    <= 1'b0;
      ex_pc_p1       <= '0;
      ex_rs1_data_p1 <= '0;
      ex_rs2_data_p1 <= '0;
      ex_imm_p1      <= '0;
      ex_rs1_p1      <= '0;
      ex_rs2_p1      <= '0;
      ex_rd_p1       <= '0;
      ex_ctrl_p1     <= '0;
    end else if (!bus.hold_i) begin
      if (bubble) begin
        // Zeroed indices keep the bubble invisible to the forwarding unit.
        ex_valid_p1 <= 1'b0;
        ex_ctrl_p1  <= '0;
        ex_rs1_p1   <= '0;
        ex_rs2_p1   <= '0;
        ex_rd_p1    <= '0;
      end else begin
        ex_valid_p1    <= bus.id_valid_i;
        ex_pc_p1       <= bus.id_pc_i;
        ex_rs1_data_p1 <= bus.id_rs1_data_i;
        ex_rs2_data_p1 <= bus.id_rs2_data_i;
        ex_imm_p1      <= bus.id_imm_i;
        ex_rs1_p1      <= bus.id_rs1_i;
        ex_rs2_p1      <= bus.id_rs2_i;
        ex_rd_p1       <= bus.id_rd_i;
        ex_ctrl_p1     <= bus.id_valid_i ? bus.id_ctrl_i : '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_p1 <= '0;
    end else if (bus.clr_cnt_i) begin
      stall_cnt_p1 <= '0;
    end else if (stall && !bus.hold_i) begin
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign bus.ex_valid_o    = ex_valid_p1;
  assign bus.ex_pc_o       = ex_pc_p1;
  assign bus.ex_rs1_data_o = ex_rs1_data_p1;
  assign bus.ex_rs2_data_o = ex_rs2_data_p1;
  assign bus.ex_imm_o      = ex_imm_p1;
  assign bus.ex_rs1_o      = ex_rs1_p1;
  assign bus.ex_rs2_o      = ex_rs2_p1;
  assign bus.ex_rd_o       = ex_rd_p1;
  assign bus.ex_ctrl_o     = ex_ctrl_p1;
  assign bus.stall_o       = stall;
  assign bus.stall_cnt_o   = stall_cnt_p1;
endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: load-use stalls, x0/rs2 exemptions,
// flush priority, hold freeze, counter saturation/clear and async reset.
module tb_id_ex_hazard_reg;
  localparam logic [10:0] LW   = 11'h01B;
  localparam logic [10:0] ADD  = 11'h001;
  localparam logic [10:0] ADDI = 11'h011;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  id_ex_hazard_reg_if #(.XLEN(32), .CTRL_W(11)) bus ();

  id_ex_hazard_reg #(.XLEN(32), .CTRL_W(11)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                        input logic u2, input logic [10:0] ctrl);
    bus.id_valid_i    = v;
    bus.id_pc_i       = pc;
    bus.id_rs1_i      = rs1;
    bus.id_rs2_i      = rs2;
    bus.id_rd_i       = rd;
    bus.id_rs1_used_i = u1;
    bus.id_rs2_used_i = u2;
    bus.id_rs1_data_i = pc ^ 32'hA5A5_0000;
    bus.id_rs2_data_i = pc ^ 32'h5A5A_0000;
    bus.id_imm_i      = pc + 32'h0000_1000;
    bus.id_ctrl_i     = ctrl;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.hold_i    = 1'b0;
    bus.flush_i   = 1'b0;
    bus.clr_cnt_i = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'h0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.ex_valid_o), 32'd0);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_cnt", bus.stall_cnt_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("idle_valid", 32'(bus.ex_valid_o), 32'd0);

    // lw x5 enters EX
    set_id(1'b1, 32'h100, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, LW);
    tick;
    chk("lw_valid", 32'(bus.ex_valid_o), 32'd1);
    chk("lw_rd", 32'(bus.ex_rd_o), 32'd5);
    chk("lw_ctrl", 32'(bus.ex_ctrl_o), 32'h01B);
    chk("lw_pc", bus.ex_pc_o, 32'h100);
    chk("lw_rs1_data", bus.ex_rs1_data_o, 32'hA5A5_0100);
    chk("lw_imm", bus.ex_imm_o, 32'h1100);

    // dependent add -> one-cycle bubble
    set_id(1'b1, 32'h104, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, ADD);
    #1;
    chk("lu_stall", 32'(bus.stall_o), 32'd1);
    tick;
    chk("lu_bub_valid", 32'(bus.ex_valid_o), 32'd0);
    chk("lu_bub_ctrl", 32'(bus.ex_ctrl_o), 32'd0);
    chk("lu_bub_rd", 32'(bus.ex_rd_o), 32'd0);
    chk("lu_bub_rs1", 32'(bus.ex_rs1_o), 32'd0);
    chk("lu_bub_pc_kept", bus.ex_pc_o, 32'h100);
    chk("lu_cnt", bus.stall_cnt_o, 32'd1);
    chk("lu_stall_gone", 32'(bus.stall_o), 32'd0);
    tick;
    chk("add_valid", 32'(bus.ex_valid_o), 32'd1);
    chk("add_rd", 32'(bus.ex_rd_o), 32'd6);
    chk("add_rs1", 32'(bus.ex_rs1_o), 32'd5);
    chk("add_pc", bus.ex_pc_o, 32'h104);
    chk("add_ctrl", 32'(bus.ex_ctrl_o), 32'h001);

    // lw x0 then use of x0: no stall
    set_id(1'b1, 32'h108, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, LW);
    tick;
    set_id(1'b1, 32'h10C, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, ADDI);
    #1;
    chk("x0_stall", 32'(bus.stall_o), 32'd0);
    tick;
    chk("x0_pc", bus.ex_pc_o, 32'h10C);
    chk("x0_valid", 32'(bus.ex_valid_o), 32'd1);

    // lw x5 then I-type with rs2 field 5 but rs2 unused: no stall
    set_id(1'b1, 32'h110, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, LW);
    tick;
    set_id(1'b1, 32'h114, 5'd3, 5'd5, 5'd8, 1'b1, 1'b0, ADDI);
    #1;
    chk("rs2u_stall", 32'(bus.stall_o), 32'd0);
    tick;
    chk("rs2u_pc", bus.ex_pc_o, 32'h114);
    chk("rs2u_rd", 32'(bus.ex_rd_o), 32'd8);
    chk("rs2u_cnt", bus.stall_cnt_o, 32'd1);

    // flush together with load-use
    set_id(1'b1, 32'h118, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, LW);
    tick;
    set_id(1'b1, 32'h11C, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, ADDI);
    bus.flush_i = 1'b1;
    #1;
    chk("fl_stall", 32'(bus.stall_o), 32'd0);
    tick;
    bus.flush_i = 1'b0;
    chk("fl_valid", 32'(bus.ex_valid_o), 32'd0);
    chk("fl_rd", 32'(bus.ex_rd_o), 32'd0);
    chk("fl_cnt", bus.stall_cnt_o, 32'd1);

    // hold for three cycles with a pending load-use
    set_id(1'b1, 32'h120, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, LW);
    tick;
    bus.hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'h124 + 32'(4 * i), 5'd0, 5'd5, 5'(6 + i), 1'b0, 1'b1, ADD);
      #1;
      chk("hd_stall", 32'(bus.stall_o), 32'd1);
      tick;
      chk("hd_pc", bus.ex_pc_o, 32'h120);
      chk("hd_valid", 32'(bus.ex_valid_o), 32'd1);
      chk("hd_rd", 32'(bus.ex_rd_o), 32'd5);
      chk("hd_cnt", bus.stall_cnt_o, 32'd1);
    end
    bus.hold_i = 1'b0;
    tick;
    chk("hr_valid", 32'(bus.ex_valid_o), 32'd0);
    chk("hr_cnt", bus.stall_cnt_o, 32'd2);

    // saturation from a preloaded count
    force dut.stall_cnt_p1 = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_p1;
    #1;
    chk("sat_preload", bus.stall_cnt_o, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'h200 + 32'(8 * i), 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, LW);
      tick;
      set_id(1'b1, 32'h204 + 32'(8 * i), 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, ADDI);
      tick;
      chk("sat_cnt", bus.stall_cnt_o, 32'hFFFF_FFFF);
    end

    // clear wins over a simultaneous stall
    set_id(1'b1, 32'h240, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, LW);
    tick;
    set_id(1'b1, 32'h244, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, ADDI);
    bus.clr_cnt_i = 1'b1;
    tick;
    bus.clr_cnt_i = 1'b0;
    chk("clr_cnt", bus.stall_cnt_o, 32'd0);
    chk("clr_valid", 32'(bus.ex_valid_o), 32'd0);

    // asynchronous reset in mid-cycle with live state
    set_id(1'b1, 32'h300, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, LW);
    tick;
    set_id(1'b1, 32'h304, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, ADDI);
    #1;
    chk("mr_pre_stall", 32'(bus.stall_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(bus.ex_valid_o), 32'd0);
    chk("mr_pc", bus.ex_pc_o, 32'd0);
    chk("mr_rd", 32'(bus.ex_rd_o), 32'd0);
    chk("mr_ctrl", 32'(bus.ex_ctrl_o), 32'd0);
    chk("mr_rs1_data", bus.ex_rs1_data_o, 32'd0);
    chk("mr_imm", bus.ex_imm_o, 32'd0);
    chk("mr_stall", 32'(bus.stall_o), 32'd0);
    chk("mr_cnt", bus.stall_cnt_o, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register for the 5-stage RV32I core, with integrated load-use hazard detection.
- Captures decoded operands and control from ID and presents them to EX.
- Its ex_rs1_o, ex_rs2_o and ex_rd_o feed the EX-stage forwarding unit; ex_ctrl_o reg_write feeds EX/MEM.
- Inserts bubbles on load-use hazards and branch flushes, freezes on memory hold, and counts stall cycles.

Parameters:
- XLEN, 32, datapath width
- CTRL_W, 11, control bundle width. Bit map: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg, [4] alu_src, [5] branch, [6] jump, [10:7] alu_op

Ports:
- clk_i  in  1  core clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- hold_i  in  1  global freeze (data-memory wait)
- flush_i  in  1  branch/jump redirect resolved in EX; kills the ID instruction
- clr_cnt_i  in  1  synchronous clear of stall counter
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  XLEN  instruction PC
- id_rs1_i, id_rs2_i, id_rd_i  in  5 each  register indices
- id_rs1_used_i, id_rs2_used_i  in  1 each  instruction reads rs1/rs2
- id_rs1_data_i, id_rs2_data_i  in  XLEN each  register-file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_ctrl_i  in  CTRL_W  decoded control
- ex_valid_o  out  1  EX instruction valid
- ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN each  registered copies
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each  registered indices (to forwarding unit)
- ex_ctrl_o  out  CTRL_W  registered control
- stall_o  out  1  combinational; holds PC and IF/ID when high
- stall_cnt_o  out  32  saturating count of load-use stall cycles

Behaviour:
- Reset (rst_n_i low, asynchronous): every registered output is 0, including stall_cnt_o. stall_o then evaluates to 0 because ex_valid_o=0.
- load_use = ex_valid_o & ex_ctrl_o[1] & (ex_rd_o!=0) & id_valid_i & ((id_rs1_used_i & id_rs1_i==ex_rd_o) | (id_rs2_used_i & id_rs2_i==ex_rd_o)).
- stall_o = load_use & ~flush_i. It is purely combinational: no registered delay.
- Register update at each rising clk_i edge, in priority order:
  1. hold_i=1: all ex_* registers keep their values. This applies even if flush_i or load_use is high.
  2. flush_i=1 or load_use=1 (bubble): ex_valid_o=0, ex_ctrl_o=0, ex_rs1_o=ex_rs2_o=ex_rd_o=0. ex_pc_o, data and imm registers retain their values.
  3. Otherwise: load all ID fields; ex_valid_o=id_valid_i; ex_ctrl_o = id_valid_i ? id_ctrl_i : 0.
- Latency: 1 cycle ID to EX.
- A load-use stall lasts exactly one cycle; the bubble clears the mem_read condition.
- A zeroed ex_rd_o ensures bubbles never match in the forwarding unit.
- x0 rule: a load to x0 never stalls.
- An instruction not using rs2 (id_rs2_used_i=0) never stalls on an rs2 match.
- Flush and load-use in the same cycle: the bubble is inserted and stall_o=0, so IF/ID advances to the redirected fetch.
- Stall counter:
  - clr_cnt_i=1 sets it to 0 (priority over increment).
  - Otherwise it increments when stall_o=1 & hold_i=0.
  - It saturates at 0xFFFFFFFF.
  - hold_i freezes it.
- Reset asserted mid-operation clears all state immediately.
- There is no reset synchronizer inside this block.

Test Plan:
- Reset: assert rst_n_i low mid-cycle with valid data loaded -> all ex_* outputs, stall_o and stall_cnt_o equal 0 before the next clock edge.
- Load-use: EX holds lw with rd=x5 (mem_read=1); ID holds add rs1=x5 -> stall_o=1 that cycle. Next edge: ex_valid_o=0, ex_ctrl_o=0, ex_rd_o=0, stall_cnt_o=1. Following edge: the add loads into EX and stall_o=0.
- No false stall: lw x0 followed by use of x0, or lw x5 followed by an I-type with rs2 field=5 and id_rs2_used_i=0 -> stall_o=0 and normal load.
- Flush priority: flush_i=1 while load_use=1 -> stall_o=0. Next edge: bubble (ex_valid_o=0), stall_cnt_o unchanged.
- Hold: hold_i=1 for 3 cycles with changing ID inputs and load_use=1 -> ex_* outputs unchanged and stall_cnt_o unchanged. Release hold -> bubble inserted, counter +1.
- Counter: preload via 0xFFFFFFFE + 3 stalls -> saturates at 0xFFFFFFFF. clr_cnt_i together with a stall -> 0.
